// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared control-bit positions and slave state encoding for the shared bus
package bus_pkg;

  localparam int CTRL_WAIT      = 0;
  localparam int CTRL_WE        = 1;
  localparam int CTRL_BURST_LSB = 2;
  localparam int CTRL_BURST_MSB = 4;
  localparam int CTRL_ERR       = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR_CAP,
    WR_MEM,
    WR_ACK,
    RD_MEM,
    RD_WAIT,
    RD_ACK,
    DONE
  } slave_state_t;

endpackage

// File: rtl/bus_slave_port_if.sv
// rtl/bus_slave_port_if.sv - per-device ack/ctrl/bus lane between bus controller and one slave
interface bus_slave_port_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8
);
  logic                  ack;
  logic [CTRL_WIDTH-1:0] ctrl_in;
  logic [BUS_WIDTH-1:0]  bus_in;
  logic [CTRL_WIDTH-1:0] ctrl_out;
  logic [BUS_WIDTH-1:0]  bus_out;

  modport master (output ack, ctrl_in, bus_in, input ctrl_out, bus_out);
  modport slave  (input ack, ctrl_in, bus_in, output ctrl_out, bus_out);
endinterface

// File: rtl/bus_slave_watchdog.sv
// rtl/bus_slave_watchdog.sv - stall counter used only when BUS_SLAVE_WATCHDOG_EN is defined
module bus_slave_watchdog
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  slave_state_t state,
  output logic         timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  slave_state_t    prev;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cur;
  logic            run;

  // cur is the number of cycles already spent in the present state
  always_comb begin
    run     = (state == WR_MEM) || (state == RD_MEM) || (state == RD_WAIT);
    cur     = (state != prev) ? '0 : count;
    timeout = run && (cur == CW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= IDLE;
      count <= '0;
    end else begin
      prev  <= state;
      count <= run ? cur + CW'(1) : '0;
    end
  end
endmodule

// File: rtl/bus_slave_port.sv
// rtl/bus_slave_port.sv - bus slave responder bridging burst transfers to a local memory port
// Optional stall watchdog enabled by defining BUS_SLAVE_WATCHDOG_EN.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int CTRL_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_slave_port_if.slave       bus,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_gnt,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_rvalid
);
  slave_state_t          state;
  logic [ADDR_WIDTH-1:0] base;
  logic [3:0]            beats;
  logic [3:0]            beat;
  logic [3:0]            beat_next;
  logic                  wait_q;
  logic                  err_q;
  logic                  discard;
  logic                  timeout;
  logic                  header;
  logic [BUS_WIDTH-1:0]  bus_out_q;
  logic                  unused_ctrl;

  assign beat_next   = beat + 4'd1;
  assign header      = bus.ack && bus.ctrl_in[CTRL_WAIT];
  assign unused_ctrl = &{1'b0, bus.ctrl_in[CTRL_WIDTH-1:CTRL_BURST_MSB+1]};

`ifdef BUS_SLAVE_WATCHDOG_EN
  bus_slave_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .state   (state),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    bus.ctrl_out           = '0;
    bus.ctrl_out[CTRL_WAIT] = wait_q;
    bus.ctrl_out[CTRL_ERR]  = err_q;
  end
  assign bus.bus_out = bus_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      beats     <= '0;
      beat      <= '0;
      wait_q    <= 1'b1;
      err_q     <= 1'b0;
      discard   <= 1'b0;
      bus_out_q <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // A read orphaned by an abort returns later; swallow exactly one rvalid for it
      if (discard && mem_rvalid) discard <= 1'b0;
      if (state != IDLE && state != DONE && !bus.ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        wait_q  <= 1'b1;
        err_q   <= 1'b0;
        if ((state == RD_MEM && mem_gnt) || (state == RD_WAIT && !mem_rvalid)) discard <= 1'b1;
      end else begin
        case (state)
          IDLE: if (header) begin
            base  <= bus.bus_in[ADDR_WIDTH-1:0];
            beats <= {1'b0, bus.ctrl_in[CTRL_BURST_MSB:CTRL_BURST_LSB]} + 4'd1;
            beat  <= '0;
            if (bus.ctrl_in[CTRL_WE]) begin
              state <= WR_CAP;
            end else begin
              state    <= RD_MEM;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= bus.bus_in[ADDR_WIDTH-1:0];
            end
          end
          WR_CAP: begin
            mem_wdata <= bus.bus_in;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= base + ADDR_WIDTH'(beat);
            state     <= WR_MEM;
          end
          WR_MEM: if (mem_gnt || timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wait_q  <= 1'b0;
            err_q   <= !mem_gnt;
            state   <= WR_ACK;
          end
          RD_MEM: if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= RD_WAIT;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            wait_q    <= 1'b0;
            err_q     <= 1'b1;
            bus_out_q <= '1;
            state     <= RD_ACK;
          end
          RD_WAIT: if (mem_rvalid && !discard) begin
            bus_out_q <= mem_rdata;
            wait_q    <= 1'b0;
            state     <= RD_ACK;
          end else if (timeout) begin
            bus_out_q <= '1;
            wait_q    <= 1'b0;
            err_q     <= 1'b1;
            discard   <= 1'b1;
            state     <= RD_ACK;
          end
          WR_ACK, RD_ACK: begin
            wait_q <= 1'b1;
            err_q  <= 1'b0;
            beat   <= beat_next;
            if (beat_next == beats) begin
              state <= DONE;
            end else if (state == WR_ACK) begin
              state <= WR_CAP;
            end else begin
              state    <= RD_MEM;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= base + ADDR_WIDTH'(beat_next);
            end
          end
          DONE: if (!bus.ack) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_slave_port.sv
// tb/tb_bus_slave_port.sv - scoreboard bench for bus_slave_port with a latency-programmable memory model
module tb_bus_slave_port;
  import bus_pkg::*;

  localparam int BW = 32;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bus_slave_port_if #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW)) bus ();

  bus_slave_port #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  typedef struct packed {logic [AW-1:0] addr; logic we; logic [BW-1:0] wdata;} acc_t;
  typedef struct packed {logic [BW-1:0] data; logic err;} rd_t;
  typedef struct {int due; bit stale;} pend_t;

  acc_t  acc_q[$];
  rd_t   rd_q[$];
  pend_t pend_q[$];

  int vectors = 0;
  int miscompares = 0;

  bit gnt_en = 1'b1;
  int rd_lat = 1;
  bit cur_rd = 1'b0;
  int abort_id = 0;

  int cyc = 0;
  int grants = 0;
  int req_cycles = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int seen_abort = 0;
  bit prev_low = 1'b0;
  bit saw_1234 = 1'b0;
  bit err_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory model and output monitor, both sampling on the falling edge
  always @(negedge clk) begin
    acc_t  a;
    pend_t p;
    rd_t   r;
    cyc++;
    if (reset) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      pend_q.delete();
      prev_low   = 1'b0;
      seen_abort = abort_id;
    end else begin
      if (seen_abort != abort_id) begin
        seen_abort = abort_id;
        foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      end
      if (mem_req) req_cycles++;
      mem_gnt = mem_req && gnt_en;
      if (mem_gnt) begin
        grants++;
        if (acc_q.size() == 0) begin
          check("unexpected_access", 64'(mem_addr), 64'hFFFF_FFFF);
        end else begin
          a = acc_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(a.addr));
          check("mem_we", 64'(mem_we), 64'(a.we));
          if (a.we) check("mem_wdata", 64'(mem_wdata), 64'(a.wdata));
        end
        if (!mem_we) begin
          p.due = cyc + rd_lat;
          p.stale = 1'b0;
          pend_q.push_back(p);
        end
      end
      mem_rvalid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p = pend_q.pop_front();
        mem_rvalid = 1'b1;
        if (p.stale) begin
          mem_rdata = 32'h0000_1234;
        end else begin
          mem_rdata = $urandom;
          r.data = mem_rdata;
          r.err  = 1'b0;
          rd_q.push_back(r);
        end
      end
      if (bus.ctrl_out[CTRL_WAIT] == 1'b0) begin
        check("wait_single_cycle", 64'(prev_low), 64'd0);
        if (cur_rd) begin
          rd_pulses++;
          if (rd_q.size() == 0) begin
            check("unexpected_rd_ack", 64'(bus.bus_out), 64'hDEAD_0000_0000);
          end else begin
            r = rd_q.pop_front();
            check("bus_out", 64'(bus.bus_out), 64'(r.data));
            check("rd_err", 64'(bus.ctrl_out[CTRL_ERR]), 64'(r.err));
          end
        end else begin
          wr_pulses++;
          check("wr_err", 64'(bus.ctrl_out[CTRL_ERR]), 64'd0);
        end
      end
      prev_low = (bus.ctrl_out[CTRL_WAIT] == 1'b0);
      if (bus.bus_out == 32'h0000_1234) saw_1234 = 1'b1;
      if (bus.ctrl_out[CTRL_ERR]) err_seen = 1'b1;
    end
  end

  task automatic send_header(input logic [AW-1:0] addr, input int n, input bit we);
    logic [2:0] bst;
    bst = 3'(n - 1);
    bus.ack     = 1'b1;
    bus.ctrl_in = {3'b000, bst, we, 1'b1};
    bus.bus_in  = BW'(addr);
    tick();
    bus.ctrl_in = {6'b0, we, 1'b0};
  endtask

  task automatic finish_xfer();
    bus.ack = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int n, input logic [BW-1:0] first);
    logic [BW-1:0] w[8];
    acc_t a;
    int start, b;
    cur_rd = 1'b0;
    start = wr_pulses;
    for (int i = 0; i < n; i++) begin
      w[i] = (i == 0) ? first : $urandom;
      a.addr = addr + AW'(i);
      a.we = 1'b1;
      a.wdata = w[i];
      acc_q.push_back(a);
    end
    send_header(addr, n, 1'b1);
    bus.bus_in = w[0];
    for (int i = 0; i < n; i++) begin
      b = 0;
      while (bus.ctrl_out[CTRL_WAIT] !== 1'b0 && b < 50) begin
        tick();
        b++;
      end
      check("wr_ack_timeout", 64'(b >= 50), 64'd0);
      if (i + 1 < n) bus.bus_in = w[i+1];
      tick();
    end
    finish_xfer();
    check("wr_pulse_count", 64'(wr_pulses - start), 64'(n));
    check("wr_acc_drained", 64'(acc_q.size()), 64'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int n);
    acc_t a;
    int start, b;
    cur_rd = 1'b1;
    start = rd_pulses;
    for (int i = 0; i < n; i++) begin
      a.addr = addr + AW'(i);
      a.we = 1'b0;
      a.wdata = '0;
      acc_q.push_back(a);
    end
    send_header(addr, n, 1'b0);
    b = 0;
    while (rd_pulses - start < n && b < 300) begin
      tick();
      b++;
    end
    check("rd_timeout", 64'(b >= 300), 64'd0);
    finish_xfer();
    check("rd_pulse_count", 64'(rd_pulses - start), 64'(n));
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int g0, b;
    logic [BW-1:0] held;
    reset       = 1'b1;
    bus.ack     = 1'b0;
    bus.ctrl_in = '0;
    bus.bus_in  = '0;
    #12;
    check("rst_ctrl_out", 64'(bus.ctrl_out), 64'h01);
    check("rst_bus_out", 64'(bus.bus_out), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    do_write(16'h0040, 1, 32'hDEAD_BEEF);
    do_write(16'hFFFF, 2, 32'h0BAD_F00D);
    rd_lat = 2;
    do_read(16'h0100, 4);
    rd_lat = 1;
    do_write(16'h1230, 8, 32'hCAFE_0001);
    do_read(16'h1230, 8);

    // abort after grant, before rvalid
    rd_lat = 4;
    cur_rd = 1'b1;
    acc_q.push_back('{addr: 16'h0200, we: 1'b0, wdata: '0});
    g0 = grants;
    send_header(16'h0200, 1, 1'b0);
    b = 0;
    while (grants == g0 && b < 50) begin
      tick();
      b++;
    end
    check("abort_grant_timeout", 64'(b >= 50), 64'd0);
    held = bus.bus_out;
    bus.ack = 1'b0;
    abort_id++;
    tick();
    check("abort_ctrl_out", 64'(bus.ctrl_out), 64'h01);
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_bus_out", 64'(bus.bus_out), 64'(held));
    do_read(16'h0300, 1);
    rd_lat = 1;
    repeat (6) tick();

    // reset while stalled in WR_MEM
    gnt_en = 1'b0;
    cur_rd = 1'b0;
    send_header(16'h0700, 1, 1'b1);
    bus.bus_in = 32'h5555_AAAA;
    b = 0;
    while (mem_req !== 1'b1 && b < 20) begin
      tick();
      b++;
    end
    check("stall_req_timeout", 64'(b >= 20), 64'd0);
    reset = 1'b1;
    #1;
    check("async_rst_mem_req", 64'(mem_req), 64'd0);
    check("async_rst_ctrl_out", 64'(bus.ctrl_out), 64'h01);
    check("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    bus.ack = 1'b0;
    tick();
    reset = 1'b0;
    gnt_en = 1'b1;
    tick();
    do_write(16'h0800, 1, 32'h1357_9BDF);

`ifdef BUS_SLAVE_WATCHDOG_EN
    begin
      int r0, s0;
      gnt_en = 1'b0;
      cur_rd = 1'b1;
      rd_q.push_back('{data: 32'hFFFF_FFFF, err: 1'b1});
      r0 = req_cycles;
      s0 = rd_pulses;
      send_header(16'h0500, 1, 1'b0);
      b = 0;
      while (rd_pulses == s0 && b < 100) begin
        tick();
        b++;
      end
      check("wd_timeout", 64'(b >= 100), 64'd0);
      check("wd_req_cycles", 64'(req_cycles - r0), 64'(TO));
      finish_xfer();
      gnt_en = 1'b1;
    end
`else
    check("err_never_set", 64'(err_seen), 64'd0);
`endif

    check("stale_never_on_bus", 64'(saw_1234), 64'd0);
    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
